// File: rtl/tone_sequencer_if.sv
// Control/table-programming bus between UI logic and the tone sequencer,
// plus the tone outputs that feed the sine generator.
interface tone_sequencer_if #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 16
);
    localparam int IW = $clog2(DEPTH);

    logic             wr_en;
    logic [IW-1:0]    wr_addr;
    logic [6:0]       wr_jump;
    logic [DUR_W-1:0] wr_dur;
    logic [IW:0]      num_steps;
    logic             loop;
    logic             start;
    logic             stop;
    logic [6:0]       jump_out;
    logic             tone_en;
    logic [IW-1:0]    step_idx;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_jump, wr_dur, num_steps, loop, start, stop,
        input  jump_out, tone_en, step_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_jump, wr_dur, num_steps, loop, start, stop,
        output jump_out, tone_en, step_idx, busy, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Plays a programmable table of (jump, duration) steps into the sine
// generator's phase-increment input, one-shot or looping.
module tone_sequencer #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 16,
    parameter int PRESC = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    tone_sequencer_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    typedef enum logic [0:0] {IDLE, PLAY} state_t;

    state_t           state_q, state_d;
    logic [6:0]       tbl_jump_q [DEPTH];
    logic [DUR_W-1:0] tbl_dur_q  [DEPTH];
    logic [IW-1:0]    idx_q, idx_d, nxt_idx;
    logic [6:0]       jump_q, jump_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [IW:0]      n_q, n_d, n_clamp;
    logic             loop_q, loop_d;
    logic             done_q, done_d;
    logic             tick, step_end, last_step;

    assign tick      = (pre_q == PW'(PRESC - 1));
    // A zero-duration step ends on its first cycle; otherwise on the tick that
    // would take the remaining count from 1 to 0.
    assign step_end  = (dur_q == '0) || ((dur_q == DUR_W'(1)) && tick);
    assign last_step = (((IW+1)'(idx_q) + (IW+1)'(1)) >= n_q);
    assign n_clamp   = (bus.num_steps > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : bus.num_steps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_jump_q[i] <= '0;
                tbl_dur_q[i]  <= '0;
            end
        end else if ((state_q == IDLE) && bus.wr_en) begin
            tbl_jump_q[bus.wr_addr] <= bus.wr_jump;
            tbl_dur_q[bus.wr_addr]  <= bus.wr_dur;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        jump_d  = jump_q;
        dur_d   = dur_q;
        pre_d   = pre_q;
        n_d     = n_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        nxt_idx = last_step ? '0 : idx_q + IW'(1);
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.num_steps != '0)) begin
                    state_d = PLAY;
                    n_d     = n_clamp;
                    loop_d  = bus.loop;
                    idx_d   = '0;
                    jump_d  = tbl_jump_q[0];
                    dur_d   = tbl_dur_q[0];
                    pre_d   = '0;
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    jump_d  = '0;
                end else if (step_end && last_step && !loop_q) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    jump_d  = '0;
                    done_d  = 1'b1;
                end else if (step_end) begin
                    idx_d  = nxt_idx;
                    jump_d = tbl_jump_q[nxt_idx];
                    dur_d  = tbl_dur_q[nxt_idx];
                    pre_d  = '0;
                end else begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick && (dur_q != '0)) dur_d = dur_q - DUR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            jump_q  <= '0;
            dur_q   <= '0;
            pre_q   <= '0;
            n_q     <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            jump_q  <= jump_d;
            dur_q   <= dur_d;
            pre_q   <= pre_d;
            n_q     <= n_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    assign bus.jump_out = jump_q;
    assign bus.tone_en  = (state_q == PLAY);
    assign bus.busy     = (state_q == PLAY);
    assign bus.step_idx = idx_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized bench for tone_sequencer against a per-cycle expected trace
// built from the step table (jump held max(1, dur*PRESC) cycles per step).
module tb_tone_sequencer;
    localparam int DEPTH = 8;
    localparam int DUR_W = 16;
    localparam int PRESC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_j [DEPTH];
    int   m_d [DEPTH];

    tone_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

    tone_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .PRESC(PRESC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_jump"}, 32'(bus.jump_out), 32'd0);
        check({tag, "_tone"}, 32'(bus.tone_en), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_idx"},  32'(bus.step_idx), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_j[i] = 0;
            m_d[i] = 0;
        end
    endtask

    task automatic write_entry(input int a, input int j, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_jump = 7'(j);
        bus.wr_dur  = 16'(d);
        step();
        bus.wr_en = 1'b0;
        m_j[a] = j;
        m_d[a] = d;
    endtask

    // Start a sequence and compare every cycle with the trace derived from the model table.
    task automatic run_seq(input int ns, input bit lp, input int loop_cycles, input bit rand_wr);
        int n;
        int total;
        int e;
        int ej[$];
        int ei[$];
        n = (ns > DEPTH) ? DEPTH : ns;
        for (int k = 0; k < n; k++) begin
            int reps;
            reps = (m_d[k] == 0) ? 1 : m_d[k] * PRESC;
            for (int r = 0; r < reps; r++) begin
                ej.push_back(m_j[k]);
                ei.push_back(k);
            end
        end
        bus.num_steps = 4'(ns);
        bus.loop      = lp;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.num_steps = 4'($urandom_range(0, 15));
        bus.loop      = 1'($urandom_range(0, 1));
        if (n == 0) begin
            check_idle("zero_n", 1'b0);
            step();
            check_idle("zero_n2", 1'b0);
            return;
        end
        total = lp ? loop_cycles : ej.size();
        for (int c = 0; c < total; c++) begin
            e = c % ej.size();
            check("play_jump", 32'(bus.jump_out), 32'(ej[e]));
            check("play_idx",  32'(bus.step_idx), 32'(ei[e]));
            check("play_tone", 32'(bus.tone_en), 32'd1);
            check("play_busy", 32'(bus.busy), 32'd1);
            check("play_done", 32'(bus.done), 32'd0);
            if (rand_wr) begin
                bus.wr_en   = 1'($urandom_range(0, 1));
                bus.wr_addr = 3'($urandom_range(0, DEPTH - 1));
                bus.wr_jump = 7'($urandom);
                bus.wr_dur  = 16'($urandom_range(0, 3));
                bus.start   = 1'($urandom_range(0, 1));
            end
            step();
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        if (lp) begin
            check("loop_still_busy", 32'(bus.busy), 32'd1);
            bus.stop = 1'b1;
            step();
            bus.stop = 1'b0;
            check_idle("stop", 1'b0);
            step();
            check_idle("stop2", 1'b0);
        end else begin
            check_idle("end", 1'b1);
            step();
            check_idle("end2", 1'b0);
        end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_jump = '0; bus.wr_dur = '0;
        bus.num_steps = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        clear_model();
        step();
        step();
        check_idle("reset", 1'b0);
        rst_n = 1'b1;
        step();

        // Basic one-shot and zero-duration steps
        write_entry(0, 5, 2);
        write_entry(1, 9, 1);
        run_seq(2, 1'b0, 0, 1'b0);
        write_entry(0, 3, 0);
        write_entry(1, 7, 1);
        run_seq(2, 1'b0, 0, 1'b0);

        // Looping with stop; done must never fire
        write_entry(0, 5, 2);
        write_entry(1, 9, 1);
        run_seq(2, 1'b1, 30, 1'b0);

        // Guards: zero steps, start+stop, oversize count, writes during play
        run_seq(0, 1'b0, 0, 1'b0);
        bus.num_steps = 4'd2; bus.start = 1'b1; bus.stop = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        check_idle("start_stop", 1'b0);
        step();
        check_idle("start_stop2", 1'b0);
        for (int i = 0; i < DEPTH; i++) write_entry(i, 10 + i, 1);
        run_seq(12, 1'b0, 0, 1'b1);
        run_seq(12, 1'b0, 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++)
                write_entry($urandom_range(0, DEPTH - 1), $urandom_range(0, 127), $urandom_range(0, 3));
            run_seq($urandom_range(0, 12), 1'b0, 0, 1'b1);
        end
        run_seq($urandom_range(1, 8), 1'b1, 40, 1'b1);

        // Asynchronous reset mid-step, then the cleared table plays a single 1-cycle step
        write_entry(0, 5, 2);
        bus.num_steps = 4'd1; bus.loop = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst", 1'b0);
        clear_model();
        step();
        rst_n = 1'b1;
        step();
        run_seq(1, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
